// File: rtl/qubit_debiaser.sv
// qubit_debiaser: turns active-low measured-qubit strobes into von Neumann
// debiased random words. Each PMOD line is synchronised and debounced, and
// its falling edge becomes a one-cycle event. The |0>/|1> events are paired
// into unbiased bits and packed LSB-first into a valid/ready output register.
module qubit_debiaser #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WORD_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            qubit,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  overflow,
    output logic                  collision,
    output logic [3:0]            led
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    // bit counter is at least 3 bits wide so led can always show [2:0]
    localparam int BCW = ($clog2(WORD_WIDTH + 1) < 3) ? 3 : $clog2(WORD_WIDTH + 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BCW-1:0] BC_FULL = BCW'(WORD_WIDTH);

    typedef enum logic [1:0] {PAIR_EMPTY, PAIR_HOLD0, PAIR_HOLD1} pair_t;

    logic [SYNC_STAGES-1:0] sync_r [3];
    logic [2:0]             sync_s;
    logic [2:0]             level_r;
    logic [DCW-1:0]         cnt_r [3];
    logic [2:0]             ev_r;     // {evclr, ev1, ev0}

    pair_t                  pair_r, pair_nxt_s;
    logic                   emit_s, emit_bit_s, collide_s;

    logic [WORD_WIDTH-1:0]  shift_r, shift_nxt_s;
    logic [BCW-1:0]         bit_cnt_r, bit_cnt_nxt_s, base_s;
    logic [WORD_WIDTH-1:0]  word_data_r, word_data_nxt_s;
    logic                   word_valid_r, word_valid_nxt_s;
    logic                   overflow_r, overflow_nxt_s;
    logic                   collision_r, collision_nxt_s;

    // line 3 is reserved; it is deliberately left unconnected
    logic                   unused_s;
    assign unused_s = qubit[3];

    // synchroniser chains, idle (high) out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 3; l++) sync_r[l] <= {SYNC_STAGES{1'b1}};
        end else begin
            for (int l = 0; l < 3; l++) sync_r[l] <= {sync_r[l][SYNC_STAGES-2:0], qubit[l]};
        end
    end

    // pick the last stage of each synchroniser
    always_comb begin
        sync_s = 3'b111;
        for (int l = 0; l < 3; l++) sync_s[l] = sync_r[l][SYNC_STAGES-1];
    end

    // debounce each line; a 1->0 flip of the accepted level is one event pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 3'b111;
            ev_r    <= 3'b000;
            for (int l = 0; l < 3; l++) cnt_r[l] <= '0;
        end else begin
            for (int l = 0; l < 3; l++) begin
                ev_r[l] <= 1'b0;
                if (sync_s[l] != level_r[l]) begin
                    if (cnt_r[l] == DB_LAST) begin
                        level_r[l] <= ~level_r[l];
                        cnt_r[l]   <= '0;
                        ev_r[l]    <= level_r[l];
                    end else begin
                        cnt_r[l] <= cnt_r[l] + DCW'(1);
                    end
                end else begin
                    cnt_r[l] <= '0;
                end
            end
        end
    end

    // von Neumann pairing next state; colliding events leave the state alone
    always_comb begin
        pair_nxt_s = pair_r;
        emit_s     = 1'b0;
        emit_bit_s = 1'b0;
        collide_s  = 1'b0;
        if (ev_r[2]) begin
            pair_nxt_s = PAIR_EMPTY;
        end else if (ev_r[0] && ev_r[1]) begin
            collide_s = 1'b1;
        end else if (ev_r[0] || ev_r[1]) begin
            case (pair_r)
                PAIR_EMPTY: pair_nxt_s = ev_r[1] ? PAIR_HOLD1 : PAIR_HOLD0;
                PAIR_HOLD0: begin
                    pair_nxt_s = PAIR_EMPTY;
                    if (ev_r[1]) begin
                        emit_s     = 1'b1;
                        emit_bit_s = 1'b0;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                PAIR_HOLD1: begin
                    pair_nxt_s = PAIR_EMPTY;
                    if (ev_r[0]) begin
                        emit_s     = 1'b1;
                        emit_bit_s = 1'b1;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                default: pair_nxt_s = PAIR_EMPTY;
            endcase
        end else begin
            pair_nxt_s = pair_r;
        end
    end

    // pairing state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pair_r <= PAIR_EMPTY;
        else        pair_r <= pair_nxt_s;
    end

    // packing, word hand-off, overflow/collision flags and clear
    always_comb begin
        shift_nxt_s      = shift_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        base_s           = bit_cnt_r;
        word_data_nxt_s  = word_data_r;
        word_valid_nxt_s = word_valid_r;
        overflow_nxt_s   = overflow_r;
        collision_nxt_s  = collision_r;
        if (ev_r[2]) begin
            shift_nxt_s      = '0;
            bit_cnt_nxt_s    = '0;
            word_data_nxt_s  = '0;
            word_valid_nxt_s = 1'b0;
            overflow_nxt_s   = 1'b0;
            collision_nxt_s  = 1'b0;
        end else begin
            collision_nxt_s = collision_r | collide_s;
            if (word_valid_r && word_ready) word_valid_nxt_s = 1'b0;
            else                            word_valid_nxt_s = word_valid_r;
            if (bit_cnt_r == BC_FULL) begin
                base_s = '0;
                if (!word_valid_r || word_ready) begin
                    word_data_nxt_s  = shift_r;
                    word_valid_nxt_s = 1'b1;
                end else begin
                    overflow_nxt_s = 1'b1;
                end
            end else begin
                base_s = bit_cnt_r;
            end
            if (emit_s) begin
                for (int i = 0; i < WORD_WIDTH; i++) begin
                    if (BCW'(i) == base_s) shift_nxt_s[i] = emit_bit_s;
                    else                   shift_nxt_s[i] = shift_r[i];
                end
                bit_cnt_nxt_s = base_s + BCW'(1);
            end else begin
                bit_cnt_nxt_s = base_s;
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            word_data_r  <= '0;
            word_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            collision_r  <= 1'b0;
        end else begin
            shift_r      <= shift_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            word_data_r  <= word_data_nxt_s;
            word_valid_r <= word_valid_nxt_s;
            overflow_r   <= overflow_nxt_s;
            collision_r  <= collision_nxt_s;
        end
    end

    assign word_data  = word_data_r;
    assign word_valid = word_valid_r;
    assign overflow   = overflow_r;
    assign collision  = collision_r;
    assign led        = {overflow_r, bit_cnt_r[2:0]};

endmodule

// File: tb/tb_qubit_debiaser.sv
// Directed bench for qubit_debiaser: expected words go into a scoreboard
// queue when stimulus is driven and are compared when the DUT hands them off.
module tb_qubit_debiaser;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] qubit;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic       overflow;
    logic       collision;
    logic [3:0] led;

    int         checks = 0;
    int         errors = 0;
    int         valid_cycles = 0;
    logic [7:0] sb [$];

    qubit_debiaser #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(D), .WORD_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .qubit(qubit),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .overflow(overflow), .collision(collision), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one strobe: line low long enough to be accepted, then idle again
    task automatic strobe(input int line);
        qubit[line] = 1'b0;
        tick(D + 4);
        qubit[line] = 1'b1;
        tick(D + 4);
    endtask

    // pair 1,0 emits 1; pair 0,1 emits 0
    task automatic pair(input logic b);
        if (b) begin strobe(1); strobe(0); end
        else   begin strobe(0); strobe(1); end
    endtask

    task automatic emit_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) pair(w[i]);
    endtask

    // scoreboard side: a transfer happens at the next rising edge
    always @(negedge clk) begin
        if (word_valid) valid_cycles++;
        if (word_valid && word_ready) begin
            chk("word_pending", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) chk("word_data", {24'd0, word_data}, {24'd0, sb.pop_front()});
        end
    end

    initial begin
        logic [7:0] w2;
        qubit      = 4'hF;
        word_ready = 1'b0;
        rst_n      = 1'b0;
        tick(4);
        chk("rst_word_data", {24'd0, word_data}, 32'd0);
        chk("rst_valid", {31'd0, word_valid}, 32'd0);
        rst_n = 1'b1;
        tick(100);
        // 1: idle for 100 cycles
        chk("idle_led", {28'd0, led}, 32'd0);
        chk("idle_valid", {31'd0, word_valid}, 32'd0);
        chk("idle_overflow", {31'd0, overflow}, 32'd0);
        chk("idle_collision", {31'd0, collision}, 32'd0);

        // 2: word A5 with consumer always ready
        word_ready   = 1'b1;
        valid_cycles = 0;
        w2 = 8'hA5;
        sb.push_back(w2);
        for (int i = 0; i < 8; i++) begin
            pair(w2[i]);
            chk("a5_led", {28'd0, led}, (i == 7) ? 32'd0 : 32'(i + 1));
        end
        chk("a5_valid_cycles", 32'(valid_cycles), 32'd1);
        chk("a5_drained", 32'(sb.size()), 32'd0);

        // 3: equal pairs emit nothing
        strobe(0); strobe(0);
        chk("pair00_led", {28'd0, led}, 32'd0);
        strobe(1); strobe(1);
        chk("pair11_led", {28'd0, led}, 32'd0);
        strobe(0); strobe(0);
        chk("pair00b_led", {28'd0, led}, 32'd0);
        pair(1'b1);
        chk("pair10_led", {28'd0, led}, 32'd1);

        // 4: short glitch filtered, long hold gives exactly one ev0
        qubit[0] = 1'b0;
        tick(D - 2);
        qubit[0] = 1'b1;
        tick(2 * D);
        chk("glitch_led", {28'd0, led}, 32'd1);
        qubit[0] = 1'b0;
        tick(D + 2);
        qubit[0] = 1'b1;
        tick(D + 4);
        chk("hold_led", {28'd0, led}, 32'd1);
        strobe(1);   // HOLD(0) + ev1 -> emits 0
        chk("one_event_led", {28'd0, led}, 32'd2);
        strobe(2);
        chk("clr_led", {28'd0, led}, 32'd0);

        // 5: back-pressure and overflow
        word_ready = 1'b0;
        sb.push_back(8'h0F);
        emit_word(8'h0F);
        chk("bp_valid", {31'd0, word_valid}, 32'd1);
        chk("bp_data", {24'd0, word_data}, 32'h0F);
        chk("bp_overflow0", {31'd0, overflow}, 32'd0);
        emit_word(8'hF0);   // dropped
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_led3", {31'd0, led[3]}, 32'd1);
        chk("ovf_data_stable", {24'd0, word_data}, 32'h0F);
        chk("ovf_valid_stable", {31'd0, word_valid}, 32'd1);
        word_ready = 1'b1;
        tick(2);
        chk("drain_valid", {31'd0, word_valid}, 32'd0);
        chk("drain_sb", 32'(sb.size()), 32'd0);
        strobe(2);
        chk("clr_overflow", {31'd0, overflow}, 32'd0);
        chk("clr_led2", {28'd0, led}, 32'd0);

        // 6: collision keeps HOLD(0); reset mid-word discards partial word
        pair(1'b1); pair(1'b0); pair(1'b1); pair(1'b1);
        strobe(0);
        chk("pre_col_led", {28'd0, led}, 32'd4);
        qubit[1:0] = 2'b00;
        tick(D + 4);
        qubit[1:0] = 2'b11;
        tick(D + 4);
        chk("col_flag", {31'd0, collision}, 32'd1);
        chk("col_led", {28'd0, led}, 32'd4);
        strobe(1);
        chk("col_hold_kept", {28'd0, led}, 32'd5);
        rst_n = 1'b0;
        tick(3);
        chk("mid_rst_led", {28'd0, led}, 32'd0);
        chk("mid_rst_collision", {31'd0, collision}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        sb.push_back(8'h3C);
        emit_word(8'h3C);
        tick(2);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_led", {28'd0, led}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
